// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encodings and HD44780 command constants for lcd_seq
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_REFRESH
    } seq_state_e;

    typedef enum logic [1:0] {
        TX_ISSUE,
        TX_ACK,
        TX_DONE
    } tx_state_e;

    localparam logic [7:0] FUNC_SET   = 8'h38;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] ENTRY_MODE = 8'h06;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] LINE1_ADDR = 8'h80;
    localparam logic [7:0] LINE2_ADDR = 8'hC0;
    localparam logic [7:0] BLANK      = 8'h20;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = FUNC_SET;
            2'd1:    cmd = DISP_ON;
            2'd2:    cmd = ENTRY_MODE;
            default: cmd = CLEAR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_buf.sv
// rtl/lcd_buf.sv - 32x8 display buffer, one write port, one async read port, resets to blanks
module lcd_buf
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_q [32];
    logic [7:0] mem_d [32];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= BLANK;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lcd_seq.sv
// rtl/lcd_seq.sv - LCD init/refresh sequencer; LCD_PERIODIC_REFRESH_EN adds a timed auto-refresh
module lcd_seq
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES = 750000,
    parameter int REFRESH_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       buf_we,
    input  logic [4:0] buf_addr,
    input  logic [7:0] buf_wdata,
    input  logic       refresh,
    output logic       busy,
    output logic [7:0] lcd_din,
    output logic       lcd_regsel,
    output logic       lcd_activate,
    input  logic       lcd_ready
);

    localparam int MAX_CYC = (POWERUP_CYCLES > REFRESH_CYCLES) ? POWERUP_CYCLES : REFRESH_CYCLES;
    localparam int DLY_W   = $clog2(MAX_CYC + 1);

    seq_state_e       state_q, state_d;
    tx_state_e        tx_q, tx_d;
    logic [4:0]       idx_q, idx_d;
    logic             addr_cmd_q, addr_cmd_d;
    logic             pend_q, pend_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             busy_q, busy_d;
    logic [7:0]       din_q, din_d;
    logic             regsel_q, regsel_d;
    logic             act_q, act_d;

    logic [7:0] buf_rdata;
    logic [7:0] cur_byte;
    logic       cur_rs;
    logic       tx_done;
    logic       req;

    lcd_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (buf_we),
        .waddr (buf_addr),
        .wdata (buf_wdata),
        .raddr (idx_q),
        .rdata (buf_rdata)
    );

`ifdef LCD_PERIODIC_REFRESH_EN
    logic [DLY_W-1:0] per_q, per_d;
    logic             per_tick;

    always_comb begin
        per_tick = (per_q == DLY_W'(REFRESH_CYCLES - 1));
        per_d    = per_tick ? '0 : per_q + DLY_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end

    assign req = refresh | per_tick;
`else
    assign req = refresh;
`endif

    // Byte for the current step; the buffer is read live so late writes to unsent slots show up.
    always_comb begin
        cur_byte = BLANK;
        cur_rs   = 1'b0;
        if (state_q == ST_INIT) begin
            cur_byte = init_cmd(idx_q[1:0]);
        end else if (addr_cmd_q) begin
            cur_byte = idx_q[4] ? LINE2_ADDR : LINE1_ADDR;
        end else begin
            cur_byte = buf_rdata;
            cur_rs   = 1'b1;
        end
    end

    always_comb begin
        tx_d       = tx_q;
        din_d      = din_q;
        regsel_d   = regsel_q;
        act_d      = 1'b0;
        tx_done    = 1'b0;
        state_d    = state_q;
        idx_d      = idx_q;
        addr_cmd_d = addr_cmd_q;
        pend_d     = pend_q;
        dly_d      = dly_q;

        if (state_q == ST_INIT || state_q == ST_REFRESH) begin
            case (tx_q)
                TX_ISSUE: if (lcd_ready) begin
                    din_d    = cur_byte;
                    regsel_d = cur_rs;
                    act_d    = 1'b1;
                    tx_d     = TX_ACK;
                end
                TX_ACK: if (!lcd_ready) begin
                    tx_d = TX_DONE;
                end
                TX_DONE: if (lcd_ready) begin
                    tx_d    = TX_ISSUE;
                    tx_done = 1'b1;
                end
                default: tx_d = TX_ISSUE;
            endcase
        end

        case (state_q)
            ST_PWRUP: begin
                pend_d = pend_q | req;
                if (dly_q == DLY_W'(POWERUP_CYCLES - 1)) begin
                    state_d = ST_INIT;
                    idx_d   = '0;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            ST_INIT: begin
                pend_d = pend_q | req;
                if (tx_done) begin
                    if (idx_q[1:0] == 2'd3) begin
                        // The refresh that follows init already covers any request seen so far.
                        state_d    = ST_REFRESH;
                        idx_d      = '0;
                        addr_cmd_d = 1'b1;
                        pend_d     = 1'b0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (req) begin
                    state_d    = ST_REFRESH;
                    idx_d      = '0;
                    addr_cmd_d = 1'b1;
                end
            end
            ST_REFRESH: begin
                pend_d = pend_q | req;
                if (tx_done) begin
                    if (addr_cmd_q) begin
                        addr_cmd_d = 1'b0;
                    end else if (idx_q == 5'd31) begin
                        idx_d      = '0;
                        addr_cmd_d = 1'b1;
                        pend_d     = 1'b0;
                        if (!(pend_q || req)) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                        if (idx_q == 5'd15) begin
                            addr_cmd_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_PWRUP;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_PWRUP;
            tx_q       <= TX_ISSUE;
            idx_q      <= '0;
            addr_cmd_q <= 1'b0;
            pend_q     <= 1'b0;
            dly_q      <= '0;
            busy_q     <= 1'b1;
            din_q      <= '0;
            regsel_q   <= 1'b0;
            act_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            idx_q      <= idx_d;
            addr_cmd_q <= addr_cmd_d;
            pend_q     <= pend_d;
            dly_q      <= dly_d;
            busy_q     <= busy_d;
            din_q      <= din_d;
            regsel_q   <= regsel_d;
            act_q      <= act_d;
        end
    end

    assign busy         = busy_q;
    assign lcd_din      = din_q;
    assign lcd_regsel   = regsel_q;
    assign lcd_activate = act_q;

endmodule
